// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient loader: FSM encoding and default coefficient width.
package biquad8_pkg;

  localparam int CW_DEFAULT = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_UPDATE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// Host-written shadow store for biquad coefficients: one write port, one registered read port.
// Not reset; power-up contents are zero and survive rst_n.
module biquad8_coeff_shadow
  import biquad8_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int CW    = CW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [CW-1:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [CW-1:0]              rdata
);

  logic [CW-1:0] mem [DEPTH] = '{default: '0};

  // Write-first forwarding so a write and a commit in the same cycle load the new value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Loads shadow coefficients into the biquad DSP B cascade (shift on B1, latch into B2).
// Optional macro BIQUAD_BYPASS_ON_LOAD_EN requests IIR bypass during the load plus a drain period.
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int NCOEFF      = 12,
  parameter int CW          = CW_DEFAULT,
  parameter int BYPASS_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_i,
  input  logic [$clog2(NCOEFF)-1:0]   addr_i,
  input  logic [CW-1:0]               dat_i,
  input  logic                        commit_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o,
  output logic [CW-1:0]               coeff_dat_o,
  output logic                        coeff_wr_o,
  output logic                        coeff_update_o,
  output logic                        bypass_o
);

  localparam int AW      = $clog2(NCOEFF);
  localparam int CNT_MAX = (NCOEFF > BYPASS_HOLD + 1) ? NCOEFF : BYPASS_HOLD + 1;
  localparam int CNTW    = $clog2(CNT_MAX);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            overrun_reg, overrun_next;
  logic            coeff_wr_reg, coeff_wr_next;
  logic            coeff_update_reg, coeff_update_next;
  logic            fin_reg, fin_next;
  logic [CW-1:0]   coeff_dat_reg, coeff_dat_next;
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   rd_data;
  logic            sh_we;
`ifdef BIQUAD_BYPASS_ON_LOAD_EN
  logic            bypass_reg, bypass_next;
`endif

  assign sh_we = wr_i && !busy_reg && (int'(addr_i) < NCOEFF);

  biquad8_coeff_shadow #(
    .DEPTH (NCOEFF),
    .CW    (CW)
  ) u_shadow (
    .clk   (clk),
    .we    (sh_we),
    .waddr (addr_i),
    .wdata (dat_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      overrun_reg      <= 1'b0;
      coeff_wr_reg     <= 1'b0;
      coeff_update_reg <= 1'b0;
      fin_reg          <= 1'b0;
      coeff_dat_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      overrun_reg      <= overrun_next;
      coeff_wr_reg     <= coeff_wr_next;
      coeff_update_reg <= coeff_update_next;
      fin_reg          <= fin_next;
      coeff_dat_reg    <= coeff_dat_next;
    end
  end

`ifdef BIQUAD_BYPASS_ON_LOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_reg <= 1'b0;
    end else begin
      bypass_reg <= bypass_next;
    end
  end
  assign bypass_o = bypass_reg;
`else
  assign bypass_o = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    busy_next         = busy_reg;
    done_next         = 1'b0;
    overrun_next      = (wr_i || commit_i) && busy_reg;
    coeff_wr_next     = 1'b0;
    coeff_update_next = 1'b0;
    fin_next          = 1'b0;
    coeff_dat_next    = '0;
    rd_addr           = AW'(NCOEFF - 1);
`ifdef BIQUAD_BYPASS_ON_LOAD_EN
    bypass_next       = bypass_reg;
`endif

    // The sequence is retired one cycle after its last state so done_o trails the final strobe.
    if (fin_reg) begin
      busy_next = 1'b0;
      done_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (commit_i && !busy_reg) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          busy_next  = 1'b1;
`ifdef BIQUAD_BYPASS_ON_LOAD_EN
          bypass_next = 1'b1;
`endif
        end
      end
      ST_SHIFT: begin
        coeff_wr_next  = 1'b1;
        coeff_dat_next = rd_data;
        state_next     = ST_HOLD;
      end
      ST_HOLD: begin
        coeff_dat_next = coeff_dat_reg;
        if (cnt_reg == CNTW'(NCOEFF - 1)) begin
          state_next = ST_UPDATE;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          rd_addr    = AW'(NCOEFF - 2 - int'(cnt_reg));
          state_next = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        coeff_update_next = 1'b1;
        cnt_next          = '0;
`ifdef BIQUAD_BYPASS_ON_LOAD_EN
        state_next        = ST_DRAIN;
`else
        state_next        = ST_IDLE;
        fin_next          = 1'b1;
`endif
      end
      ST_DRAIN: begin
`ifdef BIQUAD_BYPASS_ON_LOAD_EN
        if (cnt_reg == CNTW'(BYPASS_HOLD)) begin
          state_next  = ST_IDLE;
          bypass_next = 1'b0;
          fin_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign overrun_o      = overrun_reg;
  assign coeff_wr_o     = coeff_wr_reg;
  assign coeff_update_o = coeff_update_reg;
  assign coeff_dat_o    = coeff_dat_reg;

endmodule
